// File: rtl/fifo_src_pkg.sv
// fifo_src_pkg: shared state encoding and helpers for fifo_in_source
package fifo_src_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fifo_src_buf.sv
// fifo_src_buf: DEPTH-entry circular word buffer with push, pop, full and empty
module fifo_src_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  // the extra pointer bit separates full (wrapped once) from empty
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/fifo_in_source.sv
// fifo_in_source: packs sample pairs into words and streams a burst to an Avalon-ST sink
module fifo_in_source
  import fifo_src_pkg::*;
#(
  parameter int SMP_W       = 16,
  parameter int BURST_WORDS = 1024,
  parameter int DEPTH       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               smp_valid,
  input  logic [SMP_W-1:0]   smp_data,
  output logic               out_valid,
  output logic [2*SMP_W-1:0] out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [15:0]        drop_cnt
);
  state_t state, state_n;
  logic enable_q, half, start, stop, accept, push, pop, drop, full, empty;
  logic [SMP_W-1:0] lo;
  logic [15:0] wcnt;
  assign start  = enable & ~enable_q;
  assign stop   = !enable || wcnt == 16'(BURST_WORDS);
  assign accept = state == RUN && !stop && smp_valid;
  assign pop    = out_valid && out_ready;
  // a full buffer still takes a word when the head leaves in the same cycle
  assign push   = accept && half && (!full || pop);
  assign drop   = accept && half && full && !pop;
  assign out_valid = !empty;
  fifo_src_buf #(.W(2*SMP_W), .DEPTH(DEPTH)) u_buf (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata({smp_data, lo}),
    .rdata(out_data),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    state_n = (state == IDLE && start) ? RUN :
              (state == RUN && stop) ? DRAIN :
              (state == DRAIN && empty) ? DONE :
              (state == DONE && !enable) ? IDLE : state;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      half     <= 1'b0;
      lo       <= '0;
      wcnt     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      enable_q <= enable;
      if (state == IDLE && start) begin
        wcnt     <= '0;
        half     <= 1'b0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (accept) half <= ~half;
        if (accept && !half) lo <= smp_data;
        if (push) wcnt <= wcnt + 16'd1;
        if (drop) overflow <= 1'b1;
        if (drop) drop_cnt <= sat_inc16(drop_cnt);
      end
    end
endmodule

// File: tb/tb_fifo_in_source.sv
// tb_fifo_in_source: two burst lengths driven in parallel against a queue-based reference model
module tb_fifo_in_source;
  localparam int DEPTH = 4;
  localparam int BW_A = 4;
  localparam int BW_B = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
  logic clk, reset, enable, smp_valid, out_ready;
  logic [15:0] smp_data;
  logic ov [2];
  logic [31:0] od [2];
  logic bz [2];
  logic dn [2];
  logic of [2];
  logic [15:0] dcnt [2];
  int vectors, miscompares;
  int m_st [2];
  int m_wc [2];
  int m_dc [2];
  bit m_enq [2];
  bit m_hf [2];
  bit m_ovf [2];
  logic [15:0] m_lo [2];
  logic [31:0] qa[$], qb[$], la[$], lb[$];

  fifo_in_source #(.SMP_W(16), .BURST_WORDS(BW_A), .DEPTH(DEPTH)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .smp_valid(smp_valid), .smp_data(smp_data),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .busy(bz[0]), .done(dn[0]),
    .overflow(of[0]), .drop_cnt(dcnt[0])
  );
  fifo_in_source #(.SMP_W(16), .BURST_WORDS(BW_B), .DEPTH(DEPTH)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .smp_valid(smp_valid), .smp_data(smp_data),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .busy(bz[1]), .done(dn[1]),
    .overflow(of[1]), .drop_cnt(dcnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_wc[k] = 0; m_dc[k] = 0; m_enq[k] = 0;
      m_hf[k] = 0; m_ovf[k] = 0; m_lo[k] = '0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step(input int k);
    logic [31:0] q[$];
    int bw, was;
    q = k ? qb : qa;
    bw = k ? BW_B : BW_A;
    was = q.size();
    if (was > 0 && out_ready) void'(q.pop_front());
    case (m_st[k])
      M_IDLE: if (enable && !m_enq[k]) begin
        m_st[k] = M_RUN; m_wc[k] = 0; m_hf[k] = 0; m_ovf[k] = 0; m_dc[k] = 0;
      end
      M_RUN: if (!enable || m_wc[k] == bw) m_st[k] = M_DRAIN;
        else if (smp_valid) begin
          if (!m_hf[k]) begin
            m_lo[k] = smp_data; m_hf[k] = 1;
          end else begin
            m_hf[k] = 0;
            if (q.size() < DEPTH) begin
              q.push_back({smp_data, m_lo[k]}); m_wc[k]++;
            end else begin
              m_ovf[k] = 1;
              if (m_dc[k] < 65535) m_dc[k]++;
            end
          end
        end
      M_DRAIN: if (was == 0) m_st[k] = M_DONE;
      default: if (!enable) m_st[k] = M_IDLE;
    endcase
    m_enq[k] = enable;
    if (k == 1) qb = q; else qa = q;
  endtask

  task automatic compare_all();
    logic [31:0] q[$];
    string p;
    for (int k = 0; k < 2; k++) begin
      q = k ? qb : qa;
      p = k ? "b." : "a.";
      check({p, "out_valid"}, 64'(ov[k]), 64'(q.size() > 0));
      check({p, "out_data"}, 64'(od[k]), 64'(q.size() > 0 ? q[0] : 32'd0));
      check({p, "busy"}, 64'(bz[k]), 64'(m_st[k] == M_RUN || m_st[k] == M_DRAIN));
      check({p, "done"}, 64'(dn[k]), 64'(m_st[k] == M_DONE));
      check({p, "overflow"}, 64'(of[k]), 64'(m_ovf[k]));
      check({p, "drop_cnt"}, 64'(dcnt[k]), 64'(m_dc[k]));
    end
  endtask

  task automatic cyc();
    if (ov[0] && out_ready) la.push_back(od[0]);
    if (ov[1] && out_ready) lb.push_back(od[1]);
    @(posedge clk);
    if (reset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1 compare_all();
  endtask

  task automatic feed(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      smp_valid = 1'b1;
      smp_data = 16'(first + i);
      cyc();
    end
    smp_valid = 1'b0;
  endtask

  task automatic to_idle();
    enable = 1'b0; smp_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cyc();
    la.delete();
    lb.delete();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; enable = 1'b0; smp_valid = 1'b0; smp_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    // basic burst of four words, free-flowing sink
    enable = 1'b1; out_ready = 1'b1;
    cyc();
    feed(8, 1);
    repeat (4) cyc();
    check("a.burst_words", 64'(la.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("a.burst_word", 64'(la[i]), 64'({16'(2*i+2), 16'(2*i+1)}));
    check("a.burst_done", 64'(dn[0]), 64'd1);
    check("a.burst_ovf", 64'(of[0]), 64'd0);
    // stalled sink: four words kept, two dropped
    to_idle();
    enable = 1'b1; out_ready = 1'b0;
    cyc();
    feed(12, 1);
    check("b.stall_ovf", 64'(of[1]), 64'd1);
    check("b.stall_drops", 64'(dcnt[1]), 64'd2);
    out_ready = 1'b1;
    repeat (6) cyc();
    check("b.stall_words", 64'(lb.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("b.stall_word", 64'(lb[i]), 64'({16'(2*i+2), 16'(2*i+1)}));
    // full buffer with simultaneous pop and push
    to_idle();
    enable = 1'b1; out_ready = 1'b0;
    cyc();
    feed(8, 1);
    smp_valid = 1'b1; smp_data = 16'd9;
    cyc();
    out_ready = 1'b1; smp_data = 16'd10;
    cyc();
    smp_valid = 1'b0; out_ready = 1'b0;
    cyc();
    check("b.pp_drops", 64'(dcnt[1]), 64'd0);
    check("b.pp_valid", 64'(ov[1]), 64'd1);
    feed(2, 11);
    check("b.pp_full_drop", 64'(dcnt[1]), 64'd1);
    lb.delete();
    out_ready = 1'b1;
    repeat (6) cyc();
    check("b.pp_words", 64'(lb.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("b.pp_word", 64'(lb[i]), 64'({16'(2*i+4), 16'(2*i+3)}));
    // enable falls mid-word
    to_idle();
    enable = 1'b1;
    cyc();
    feed(3, 1);
    enable = 1'b0;
    cyc();
    check("a.abort_drain", 64'({bz[0], dn[0]}), 64'b10);
    cyc();
    check("a.abort_done", 64'({bz[0], dn[0]}), 64'b01);
    cyc();
    check("a.abort_idle", 64'({bz[0], dn[0]}), 64'b00);
    check("a.abort_words", 64'(la.size()), 64'd1);
    check("a.abort_word", 64'(la[0]), 64'h00020001);
    // reset while words are buffered
    to_idle();
    enable = 1'b1; out_ready = 1'b0;
    cyc();
    feed(4, 1);
    #2 reset = 1'b1;
    #1;
    check("a.rst_valid", 64'(ov[0]), 64'd0);
    check("b.rst_valid", 64'(ov[1]), 64'd0);
    check("b.rst_data", 64'(od[1]), 64'd0);
    enable = 1'b0;
    repeat (2) cyc();
    reset = 1'b0; out_ready = 1'b1;
    la.delete(); lb.delete();
    repeat (6) cyc();
    check("a.rst_words", 64'(la.size()), 64'd0);
    check("b.rst_words", 64'(lb.size()), 64'd0);
    // samples outside RUN are ignored
    to_idle();
    repeat (10) begin
      smp_valid = 1'($urandom); smp_data = 16'($urandom);
      cyc();
      check("idle_quiet", 64'({ov[0], ov[1]}), 64'd0);
    end
    enable = 1'b1; smp_valid = 1'b0;
    cyc();
    feed(8, 1);
    repeat (4) cyc();
    repeat (10) begin
      smp_valid = 1'($urandom); smp_data = 16'($urandom);
      cyc();
      check("a.done_quiet", 64'({ov[0], dn[0]}), 64'b01);
    end
    // randomized traffic
    to_idle();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 4) enable = ~enable;
      smp_valid = $urandom_range(99) < 60;
      smp_data = 16'($urandom);
      out_ready = $urandom_range(99) < 65;
      reset = $urandom_range(999) < 3;
      cyc();
    end
    reset = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
